// File: rtl/register_file.sv
// register_file
//   16 x 16-bit general-purpose register file with two combinational read
//   ports, one synchronous write port and write-to-read bypass.
//   R0 is hardwired to zero.
//
// Ports
//   clk       in   1   system clock, writes on rising edge
//   rst       in   1   asynchronous active-high reset, clears all registers
//   SrcReg1   in   4   read port 1 register index
//   SrcReg2   in   4   read port 2 register index
//   DstReg    in   4   write port register index
//   WriteReg  in   1   write enable
//   DstData   in  16   write data
//   SrcData1  out 16   read port 1 data (combinational, bypassed)
//   SrcData2  out 16   read port 2 data (combinational, bypassed)
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  SrcReg1,
  input  logic [3:0]  SrcReg2,
  input  logic [3:0]  DstReg,
  input  logic        WriteReg,
  input  logic [15:0] DstData,
  output logic [15:0] SrcData1,
  output logic [15:0] SrcData2
);

  logic [15:0] regs [16];
  logic        wr_en;

  // R0 is never written, so a write to it is simply dropped here.
  assign wr_en = WriteReg && (DstReg != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 16'h0000;
      end
    end else if (wr_en) begin
      regs[DstReg] <= DstData;
    end
  end

  // Read path: reset and R0 force zero; otherwise the incoming write data
  // wins over the stored value when the indices match.
  always_comb begin
    SrcData1 = 16'h0000;
    if (!rst && (SrcReg1 != 4'd0)) begin
      if (wr_en && (DstReg == SrcReg1)) SrcData1 = DstData;
      else                              SrcData1 = regs[SrcReg1];
    end
  end

  always_comb begin
    SrcData2 = 16'h0000;
    if (!rst && (SrcReg2 != 4'd0)) begin
      if (wr_en && (DstReg == SrcReg2)) SrcData2 = DstData;
      else                              SrcData2 = regs[SrcReg2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [3:0]  SrcReg1, SrcReg2, DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [15:0] SrcData1, SrcData2;

  register_file dut (
    .clk      (clk),
    .rst      (rst),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .DstReg   (DstReg),
    .WriteReg (WriteReg),
    .DstData  (DstData),
    .SrcData1 (SrcData1),
    .SrcData2 (SrcData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          reps;
    logic        wr;
    logic [3:0]  dst;
    logic [15:0] data;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [15:0] e1;
    logic [15:0] e2;
  } vec_t;

  typedef struct {
    logic [15:0] e1;
    logic [15:0] e2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[16];

  task automatic drive(input logic wr, input logic [3:0] dst, input logic [15:0] data,
                       input logic [3:0] s1, input logic [3:0] s2,
                       input logic [15:0] e1, input logic [15:0] e2);
    exp_t e;
    WriteReg = wr;
    DstReg   = dst;
    DstData  = data;
    SrcReg1  = s1;
    SrcReg2  = s2;
    e.e1 = e1;
    e.e2 = e2;
    sb.push_back(e);
  endtask

  task automatic check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (SrcData1 !== e.e1 || SrcData2 !== e.e2) begin
      errors++;
      $display("FAIL %s: got SrcData1=%h SrcData2=%h expected %h %h",
               name, SrcData1, SrcData2, e.e1, e.e2);
    end
  endtask

  initial begin
    //            reps wr dst data      s1 s2 e1        e2
    tbl[0]  = '{4, 1'b1, 4'd2, 16'h2222, 4'd2, 4'd0, 16'h2222, 16'h0000};
    tbl[1]  = '{2, 1'b0, 4'd2, 16'h2222, 4'd2, 4'd4, 16'h2222, 16'h0000};
    tbl[2]  = '{4, 1'b1, 4'd4, 16'h4444, 4'd2, 4'd4, 16'h2222, 16'h4444};
    tbl[3]  = '{2, 1'b0, 4'd4, 16'h4444, 4'd4, 4'd6, 16'h4444, 16'h0000};
    tbl[4]  = '{4, 1'b1, 4'd6, 16'h6666, 4'd6, 4'd6, 16'h6666, 16'h6666};
    tbl[5]  = '{2, 1'b0, 4'd6, 16'h6666, 4'd6, 4'd8, 16'h6666, 16'h0000};
    tbl[6]  = '{4, 1'b1, 4'd8, 16'h8888, 4'd8, 4'd2, 16'h8888, 16'h2222};
    tbl[7]  = '{2, 1'b0, 4'd8, 16'h8888, 4'd8, 4'd7, 16'h8888, 16'h0000};
    tbl[8]  = '{1, 1'b0, 4'd0, 16'h0000, 4'd2, 4'd4, 16'h2222, 16'h4444};
    tbl[9]  = '{1, 1'b0, 4'd0, 16'h0000, 4'd6, 4'd8, 16'h6666, 16'h8888};
    tbl[10] = '{1, 1'b0, 4'd0, 16'h0000, 4'd7, 4'd0, 16'h0000, 16'h0000};
    tbl[11] = '{3, 1'b0, 4'd2, 16'hABCD, 4'd2, 4'd2, 16'h2222, 16'h2222};
    tbl[12] = '{1, 1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 16'h0000, 16'h0000};
    tbl[13] = '{1, 1'b0, 4'd0, 16'hFFFF, 4'd0, 4'd2, 16'h0000, 16'h2222};
    tbl[14] = '{1, 1'b1, 4'd3, 16'h1234, 4'd3, 4'd5, 16'h1234, 16'h0000};
    tbl[15] = '{1, 1'b0, 4'd3, 16'h0000, 4'd3, 4'd3, 16'h1234, 16'h1234};

    // Reset held with a live write request: outputs and storage must stay zero.
    rst = 1'b1;
    drive(1'b1, 4'd2, 16'h2222, 4'd2, 4'd2, 16'h0000, 16'h0000);
    sb.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1'b1, 4'd2, 16'h2222, 4'd2, 4'd2, 16'h0000, 16'h0000);
      check("reset_hold");
    end
    WriteReg = 1'b0;
    rst = 1'b0;

    for (int v = 0; v < 16; v++) begin
      for (int r = 0; r < tbl[v].reps; r++) begin
        @(posedge clk);
        #1;
        drive(tbl[v].wr, tbl[v].dst, tbl[v].data, tbl[v].s1, tbl[v].s2, tbl[v].e1, tbl[v].e2);
        @(negedge clk);
        check($sformatf("vec%0d_cyc%0d", v, r));
      end
    end

    // Same-cycle bypass on both ports into an empty R7, then confirm it stored.
    @(posedge clk);
    #1;
    drive(1'b1, 4'd7, 16'h7777, 4'd7, 4'd7, 16'h7777, 16'h7777);
    @(negedge clk);
    check("bypass_r7_before_edge");
    @(posedge clk);
    #1;
    drive(1'b0, 4'd7, 16'h7777, 4'd7, 4'd7, 16'h7777, 16'h7777);
    @(negedge clk);
    check("bypass_r7_stored");

    // Asynchronous reset pulse entirely between rising edges.
    @(posedge clk);
    #1;
    drive(1'b0, 4'd0, 16'h0000, 4'd2, 4'd4, 16'h2222, 16'h4444);
    #1;
    check("pre_async_reset");
    #1 rst = 1'b1;
    #1;
    drive(1'b0, 4'd0, 16'h0000, 4'd2, 4'd4, 16'h0000, 16'h0000);
    check("async_reset_active");
    #1 rst = 1'b0;
    #1;
    drive(1'b0, 4'd0, 16'h0000, 4'd2, 4'd4, 16'h0000, 16'h0000);
    check("async_reset_cleared_r2_r4");
    #1;
    drive(1'b0, 4'd0, 16'h0000, 4'd6, 4'd8, 16'h0000, 16'h0000);
    check("async_reset_cleared_r6_r8");

    // Writes resume on the next edge after reset release.
    @(posedge clk);
    #1;
    drive(1'b1, 4'd9, 16'h5A5A, 4'd9, 4'd2, 16'h5A5A, 16'h0000);
    @(negedge clk);
    check("post_reset_write_bypass");
    @(posedge clk);
    #1;
    drive(1'b0, 4'd9, 16'h0000, 4'd2, 4'd9, 16'h0000, 16'h5A5A);
    @(negedge clk);
    check("post_reset_write_stored");

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
